fpu_mul_pipe: RTL and testbench
===============================

Name: fpu_mul_pipe

Overview:
- Parametrised, pipelined floating-point multiplier; successor to the single-shot 32-bit FPU multiply datapath.
- Generic exponent/mantissa widths; a 3-stage pipeline with valid/ready handshakes on both sides; IEEE special-case handling and exception flags.
- Sits between the operand issue logic and the result writeback. Accepts one operand pair per cycle when not stalled.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width; hidden bit is implicit.
- BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- a  input  1+EXP_W+MAN_W  operand A, {sign, exp, frac}
- b  input  1+EXP_W+MAN_W  operand B
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- result  output  1+EXP_W+MAN_W  packed product
- flags  output  4  {invalid, overflow, underflow, zero}

Behaviour:
- Reset (async, active-high) clears all stage valids, out_valid, result and flags to 0. In-flight operations are discarded. No output activity until in_valid is seen after reset deasserts.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_ready.
  - Every stage register loads only when adv=1; when adv=0 all stages hold.
  - A bubble does not collapse while stalled; this is acceptable.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: exactly 3 clk edges from input transfer to out_valid, with no stall. Throughput: 1 per cycle.
- Stage 1 (unpack):
  - sign = sa ^ sb.
  - Exponent sum: ea + eb - BIAS, in EXP_W+2-bit signed arithmetic.
  - Classify each operand: zero (exp==0; denormals flush to zero), inf (exp all-ones, frac==0), NaN (exp all-ones, frac!=0).
  - Mantissas are formed as {1, frac}.
- Stage 2: unsigned (MAN_W+1)x(MAN_W+1) product, 2*MAN_W+2 bits wide. Special classification and sign are carried along.
- Stage 3 (normalise, round, pack):
  - If product MSB=1: shift right 1 and exponent +1.
  - Then round (see Optional Feature). If rounding carries out, the mantissa becomes 1.0 and the exponent increments again.
- Final exponent is checked in priority order:
  - Any NaN operand, or inf*zero: result = canonical quiet NaN {0, all-ones, 1 followed by zeros}; invalid=1.
  - Else either operand is inf: signed inf.
  - Else either operand is zero: signed zero; zero=1.
  - Else biased exponent >= all-ones: signed inf; overflow=1.
  - Else biased exponent <= 0: signed zero; underflow=1, zero=1.
  - Else normal pack.
- flags is valid only while out_valid=1. result and flags are held stable while out_valid && !out_ready.

Optional Feature:
- Macro FPU_MUL_RNE_EN.
- When defined: stage 3 rounds to nearest, ties to even, using guard bit and sticky OR of all lower product bits.
- When undefined: the fraction is truncated (round toward zero); no rounding adder is synthesised.
- Latency is unchanged in both modes.

Test Plan:
- Basic product: a=0x3FC00000, b=0x40000000, in_valid=1, out_ready=1 -> 3 cycles later out_valid=1, result=0x40400000, flags=0.
- Sign and back-to-back: pairs (0xC0000000, 0x40400000) then (0x3F800000, 0x3F800000) on consecutive cycles -> results 0xC0C00000 then 0x3F800000 on consecutive cycles.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1.
  - 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1.
  - 0x00800000 * 0x3F000000 -> 0x00000000, underflow=1, zero=1.
- Rounding: 0x3F800001 * 0x3FC00000 -> 0x3FC00002 with FPU_MUL_RNE_EN defined; 0x3FC00001 without.
- Backpressure:
  - Issue 4 ops with out_ready=0 -> in_ready drops once out_valid=1; result holds stable.
  - Then release out_ready -> all 4 results emerge in order, none lost or duplicated.
- Reset mid-operation: assert rst with 3 ops in flight -> out_valid=0 and result=0 immediately (asynchronously). No stale result appears after rst deasserts.

Source files
------------

// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: 3-stage pipelined floating-point multiplier (unpack / multiply / normalise-round-pack).
// Denormals flush to zero. Define FPU_MUL_RNE_EN for round-to-nearest-even; otherwise the fraction truncates.
module fpu_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = 127
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int EW = EXP_W + 2;
   localparam int P  = 2 * MAN_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;
   logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic signed [EW-1:0] exp_sum;

   assign {sa, ea, fa} = a;
   assign {sb, eb, fb} = b;
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_nan  = (eb == '1) && (fb != '0);
   assign exp_sum = EW'(ea) + EW'(eb) - EW'(BIAS);

   logic                 s1_valid, s1_sign, s1_invalid, s1_inf, s1_zero;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W:0]       s1_ma, s1_mb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_invalid <= 1'b0;
         s1_inf     <= 1'b0;
         s1_zero    <= 1'b0;
         s1_exp     <= '0;
         s1_ma      <= '0;
         s1_mb      <= '0;
      end else if (adv) begin
         s1_valid   <= in_valid;
         s1_sign    <= sa ^ sb;
         s1_invalid <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
         s1_inf     <= a_inf | b_inf;
         s1_zero    <= a_zero | b_zero;
         s1_exp     <= exp_sum;
         s1_ma      <= {1'b1, fa};
         s1_mb      <= {1'b1, fb};
      end
   end

   logic                 s2_valid, s2_sign, s2_invalid, s2_inf, s2_zero;
   logic signed [EW-1:0] s2_exp;
   logic [P-1:0]         s2_prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_invalid <= 1'b0;
         s2_inf     <= 1'b0;
         s2_zero    <= 1'b0;
         s2_exp     <= '0;
         s2_prod    <= '0;
      end else if (adv) begin
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_invalid <= s1_invalid;
         s2_inf     <= s1_inf;
         s2_zero    <= s1_zero;
         s2_exp     <= s1_exp;
         s2_prod    <= P'(s1_ma) * P'(s1_mb);
      end
   end

   // Product lies in [1,4): its MSB selects a one-bit normalising shift.
   logic [MAN_W-1:0]     frac_n, frac_r;
   logic signed [EW-1:0] exp_n, exp_r;

   assign frac_n = s2_prod[P-1] ? s2_prod[P-2 -: MAN_W] : s2_prod[P-3 -: MAN_W];
   assign exp_n  = s2_prod[P-1] ? s2_exp + EW'(1) : s2_exp;

`ifdef FPU_MUL_RNE_EN
   logic guard, sticky, round_up, carry;
   assign guard    = s2_prod[P-1] ? s2_prod[P-2-MAN_W] : s2_prod[P-3-MAN_W];
   assign sticky   = s2_prod[P-1] ? |s2_prod[P-3-MAN_W:0] : |s2_prod[P-4-MAN_W:0];
   assign round_up = guard & (sticky | frac_n[0]);
   // A carry out leaves frac_r at zero, i.e. mantissa 1.0 one binade up.
   assign {carry, frac_r} = {1'b0, frac_n} + (MAN_W+1)'(round_up);
   assign exp_r = carry ? exp_n + EW'(1) : exp_n;
`else
   logic unused_lsb;
   assign unused_lsb = ^s2_prod[P-3-MAN_W:0];
   assign frac_r     = frac_n;
   assign exp_r      = exp_n;
`endif

   logic [EXP_W+MAN_W:0] res_n;
   logic [3:0]           flg_n;

   always_comb begin
      res_n = {s2_sign, exp_r[EXP_W-1:0], frac_r};
      flg_n = '0;
      if (s2_invalid) begin
         res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         flg_n = 4'b1000;
      end else if (s2_inf) begin
         res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2_zero) begin
         res_n = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
         flg_n = 4'b0001;
      end else if (exp_r >= EXP_MAX) begin
         res_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_n = 4'b0100;
      end else if (exp_r <= EXP_ZERO) begin
         res_n = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
         flg_n = 4'b0011;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            result <= res_n;
            flags  <= flg_n;
         end
      end
   end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Testbench for fpu_mul_pipe: directed vectors, scoreboard against an integer-arithmetic model.
// The model follows FPU_MUL_RNE_EN the same way the design does.
module tb_fpu_mul_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [3:0]  flags;

   fpu_mul_pipe #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      bit          lit;
      logic [31:0] lres;
      logic [3:0]  lflg;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          total = 0;
   int          bad   = 0;
   bit          cur_lit;
   logic [31:0] cur_lres;
   logic [3:0]  cur_lflg;
   bit          held = 0;
   logic [31:0] hres;
   logic [3:0]  hflg;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Returns {flags, result} from exact integer product and explicit rounding of the discarded tail.
   function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, e2;
      bit s, zx, zy, ix, iy, nx, ny;
      longint unsigned p, keep, rem, half;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      s  = x[31] ^ y[31];
      zx = (ex == 0);
      zy = (ey == 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      if (nx || ny || (ix && zy) || (zx && iy)) return {4'b1000, 32'h7FC0_0000};
      if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
      if (zx || zy) return {4'b0001, s, 31'h0};
      p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      e2 = ex + ey - 127;
      if (p >= 64'h8000_0000_0000) begin
         e2++;
         keep = p >> 24;
         rem  = p % (64'd1 << 24);
         half = 64'd1 << 23;
      end else begin
         keep = p >> 23;
         rem  = p % (64'd1 << 23);
         half = 64'd1 << 22;
      end
`ifdef FPU_MUL_RNE_EN
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (64'd1 << 24)) begin
         keep = 64'd1 << 23;
         e2++;
      end
`else
      if (rem > half) keep = keep;
`endif
      if (e2 >= 255) return {4'b0100, s, 8'hFF, 23'h0};
      if (e2 <= 0)   return {4'b0011, s, 31'h0};
      return {4'b0000, s, 8'(e2), keep[22:0]};
   endfunction

   // Single compare process: scoreboard on output transfers, stability while stalled.
   always @(negedge clk) begin
      if (rst) begin
         held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, hres);
            chk("hold_flags", flags, hflg);
         end
         held = out_valid && !out_ready;
         hres = result;
         hflg = flags;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               chk("model_result", result, e.res);
               chk("model_flags", flags, e.flg);
               if (e.lit) begin
                  chk("literal_result", result, e.lres);
                  chk("literal_flags", flags, e.lflg);
               end
            end
         end
         if (in_valid && in_ready) begin
            e.res  = model(a, b)[31:0];
            e.flg  = model(a, b)[35:32];
            e.lit  = cur_lit;
            e.lres = cur_lres;
            e.lflg = cur_lflg;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [31:0] va, input logic [31:0] vb, input bit lit,
                       input logic [31:0] lr, input logic [3:0] lf);
      int n;
      n = 0;
      a = va;
      b = vb;
      cur_lit  = lit;
      cur_lres = lr;
      cur_lflg = lf;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1 chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_flags", flags, 0);
      rst = 1'b0;

      // Pin the model to hand-computed values.
      chk("pin_basic", model(32'h3FC0_0000, 32'h4000_0000), {4'b0000, 32'h4040_0000});
      chk("pin_sign", model(32'hC000_0000, 32'h4040_0000), {4'b0000, 32'hC0C0_0000});
      chk("pin_nan", model(32'h7F80_0000, 32'h0000_0000), {4'b1000, 32'h7FC0_0000});
      chk("pin_ovf", model(32'h7F00_0000, 32'h4000_0000), {4'b0100, 32'h7F80_0000});
      chk("pin_udf", model(32'h0080_0000, 32'h3F00_0000), {4'b0011, 32'h0000_0000});
`ifdef FPU_MUL_RNE_EN
      chk("pin_round", model(32'h3F80_0001, 32'h3FC0_0000), {4'b0000, 32'h3FC0_0002});
`else
      chk("pin_round", model(32'h3F80_0001, 32'h3FC0_0000), {4'b0000, 32'h3FC0_0001});
`endif

      repeat (2) @(posedge clk);
      #1 chk("idle_after_reset", out_valid, 0);

      // Basic product and latency.
      send(32'h3FC0_0000, 32'h4000_0000, 1, 32'h4040_0000, 4'h0);
      chk("lat_edge1", out_valid, 0);
      @(posedge clk); #1 chk("lat_edge2", out_valid, 0);
      @(posedge clk); #1 chk("lat_edge3", out_valid, 1);
      chk("basic_result", result, 32'h4040_0000);
      chk("basic_flags", flags, 4'h0);
      drain();

      // Back-to-back with sign.
      send(32'hC000_0000, 32'h4040_0000, 1, 32'hC0C0_0000, 4'h0);
      send(32'h3F80_0000, 32'h3F80_0000, 1, 32'h3F80_0000, 4'h0);
      @(posedge clk); #1;
      chk("b2b_first_valid", out_valid, 1);
      chk("b2b_first", result, 32'hC0C0_0000);
      @(posedge clk); #1;
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second", result, 32'h3F80_0000);
      drain();

      // Specials, rounding and further directed vectors.
      send(32'h7F80_0000, 32'h0000_0000, 1, 32'h7FC0_0000, 4'b1000);
      send(32'h7F00_0000, 32'h4000_0000, 1, 32'h7F80_0000, 4'b0100);
      send(32'h0080_0000, 32'h3F00_0000, 1, 32'h0000_0000, 4'b0011);
`ifdef FPU_MUL_RNE_EN
      send(32'h3F80_0001, 32'h3FC0_0000, 1, 32'h3FC0_0002, 4'b0000);
`else
      send(32'h3F80_0001, 32'h3FC0_0000, 1, 32'h3FC0_0001, 4'b0000);
`endif
      send(32'hFF80_0000, 32'h4000_0000, 1, 32'hFF80_0000, 4'b0000);
      send(32'h8000_0000, 32'h4040_0000, 1, 32'h8000_0000, 4'b0001);
      send(32'h0040_0000, 32'h4000_0000, 1, 32'h0000_0000, 4'b0001);
      send(32'h7F80_0001, 32'h3F80_0000, 1, 32'h7FC0_0000, 4'b1000);
      send(32'h0000_0000, 32'hFF80_0000, 1, 32'h7FC0_0000, 4'b1000);
      send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1, 32'h7F80_0000, 4'b0100);
      send(32'hBF80_0000, 32'h0080_0000, 1, 32'h8080_0000, 4'b0000);
      send(32'h4049_0FDB, 32'h402D_F854, 0, '0, '0);
      send(32'h3F80_0003, 32'h3FAA_AAAB, 0, '0, '0);
      send(32'h3FFF_FFFF, 32'h3FFF_FFFF, 0, '0, '0);
      drain();

      // Backpressure: four ops with the sink stalled, then released.
      out_ready = 1'b0;
      fork
         begin
            send(32'h3FC0_0000, 32'h4000_0000, 1, 32'h4040_0000, 4'h0);
            send(32'hC000_0000, 32'h4040_0000, 1, 32'hC0C0_0000, 4'h0);
            send(32'h3F80_0000, 32'h3F80_0000, 1, 32'h3F80_0000, 4'h0);
            send(32'h4000_0000, 32'h4000_0000, 1, 32'h4080_0000, 4'h0);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            repeat (4) @(posedge clk);
            #1;
            chk("stall_in_ready_late", in_ready, 0);
            chk("stall_result", result, 32'h4040_0000);
            out_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset with three ops in flight.
      send(32'h3FC0_0000, 32'h4000_0000, 0, '0, '0);
      send(32'hC000_0000, 32'h4040_0000, 0, '0, '0);
      send(32'h3F80_0000, 32'h3F80_0000, 0, '0, '0);
      chk("pre_reset_valid", out_valid, 1);
      #2 rst = 1'b1;
      q.delete();
      #1;
      chk("async_reset_valid", out_valid, 0);
      chk("async_reset_result", result, 0);
      chk("async_reset_flags", flags, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("no_stale_after_reset", out_valid, 0);

      // Pipeline still works after reset.
      send(32'h4000_0000, 32'h4040_0000, 1, 32'h40C0_0000, 4'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
